// File: rtl/audio_mixer_pkg.sv
// Shared types and width helpers for the audio mixer.
// Build option: AUDIO_MIXER_SATURATE_EN selects clamp instead of wrap.
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  function automatic int acc_width(
    input int sample_w,
    input int num_ch
  );
    return sample_w + $clog2(num_ch);
  endfunction

endpackage

// File: rtl/mixer_clamp.sv
// Narrows the accumulator to the output width.
// AUDIO_MIXER_SATURATE_EN: clamp to full scale, else modulo wrap.
module mixer_clamp #(
  parameter int IN_WIDTH  = 11,
  parameter int OUT_WIDTH = 11
) (
  input  logic [IN_WIDTH-1:0]  i_value,
  output logic [OUT_WIDTH-1:0] o_value
);

  if (OUT_WIDTH >= IN_WIDTH) begin : g_ext
    assign o_value = OUT_WIDTH'(i_value);
  end else begin : g_narrow
`ifdef AUDIO_MIXER_SATURATE_EN
    localparam logic [OUT_WIDTH-1:0] MAX = '1;
    assign o_value = (|i_value[IN_WIDTH-1:OUT_WIDTH]) ?
                     MAX : i_value[OUT_WIDTH-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^i_value[IN_WIDTH-1:OUT_WIDTH];
    assign o_value   = i_value[OUT_WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/audio_mixer.sv
// Sequential N-channel mixer: one channel per cycle into a wide accumulator.
// Build option: AUDIO_MIXER_SATURATE_EN (see mixer_clamp).
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SAMPLE_WIDTH = 9,
  parameter int OUT_WIDTH    = 11
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] i_samples,
  input  logic                                 i_sample_stb,
  input  logic [NUM_CHANNELS-1:0]              i_mute_mask,
  output logic [OUT_WIDTH-1:0]                 o_sample,
  output logic                                 o_sample_valid,
  output logic                                 o_busy,
  output logic                                 o_overrun
);

  localparam int ACC_W = acc_width(SAMPLE_WIDTH, NUM_CHANNELS);
  localparam int IDX_W = $clog2(NUM_CHANNELS);
  localparam int TOT_W = NUM_CHANNELS * SAMPLE_WIDTH;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [TOT_W-1:0]        snap_q, snap_d;
  logic [NUM_CHANNELS-1:0] mask_q, mask_d;
  logic [OUT_WIDTH-1:0]    out_q, out_d;
  logic                    valid_q, valid_d;
  logic                    ovr_q, ovr_d;

  logic [SAMPLE_WIDTH-1:0] chan;
  logic                    chan_mute;
  logic [OUT_WIDTH-1:0]    narrow;

  mixer_clamp #(
    .IN_WIDTH  (ACC_W),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_clamp (
    .i_value (acc_q),
    .o_value (narrow)
  );

  always_comb begin
    chan      = '0;
    chan_mute = 1'b0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        chan      = snap_q[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        chan_mute = mask_q[k];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    snap_d  = snap_q;
    mask_d  = mask_q;
    out_d   = out_q;
    valid_d = 1'b0;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE: begin
        if (i_sample_stb) begin
          snap_d  = i_samples;
          mask_d  = i_mute_mask;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (!chan_mute) acc_d = acc_q + ACC_W'(chan);
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CHANNELS-1)) state_d = DONE;
        if (i_sample_stb) ovr_d = 1'b1;
      end
      DONE: begin
        out_d   = narrow;
        valid_d = 1'b1;
        state_d = IDLE;
        if (i_sample_stb) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      snap_q  <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      snap_q  <= snap_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_sample       = out_q;
  assign o_sample_valid = valid_q;
  assign o_busy         = (state_q != IDLE);
  assign o_overrun      = ovr_q;

endmodule
